// File: rtl/tile_pixel_drawer_if.sv
// Drawer bus: load/draw strobes from the game controller in,
// pixel stream (x/y/colour/plot) and busy/draw_done status out.
interface tile_pixel_drawer_if;
  logic       ld_tile;
  logic       ld_flash;
  logic [2:0] tile_num;
  logic       writeEnable;
  logic       counterEnable;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       draw_done;

  modport master (
    output ld_tile, ld_flash, tile_num,
    output writeEnable, counterEnable,
    input  x, y, colour, plot, busy, draw_done
  );

  modport slave (
    input  ld_tile, ld_flash, tile_num,
    input  writeEnable, counterEnable,
    output x, y, colour, plot, busy, draw_done
  );
endinterface

// File: rtl/tile_pixel_drawer.sv
// Walks one square tile a pixel per clock for the VGA adapter.
// Ports: clock, resetn (sync, active-low), bus (slave side).
module tile_pixel_drawer #(
  parameter int         TILE_SIZE    = 16,
  parameter int         X_ORIGIN     = 48,
  parameter int         Y_ORIGIN     = 28,
  parameter int         GAP          = 4,
  parameter logic [2:0] FLASH_COLOUR = 3'b111
) (
  input logic clock,
  input logic resetn,
  tile_pixel_drawer_if.slave bus
);

  localparam int CW = $clog2(TILE_SIZE);
  localparam logic [CW-1:0] LAST = CW'(TILE_SIZE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [7:0] BX0  = 8'(X_ORIGIN);
  localparam logic [7:0] BX1  = 8'(X_ORIGIN + TILE_SIZE + GAP);
  localparam logic [6:0] BY0  = 7'(Y_ORIGIN);
  localparam logic [6:0] BY1  = 7'(Y_ORIGIN + TILE_SIZE + GAP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [2:0] normal_colour(
    input logic [1:0] k
  );
    logic [2:0] c;
    c = 3'b000;
    unique case (k)
      2'd0: c = 3'b100;
      2'd1: c = 3'b010;
      2'd2: c = 3'b001;
      2'd3: c = 3'b110;
    endcase
    return c;
  endfunction

  state_t        state_q;
  logic [1:0]    active_tile_q;
  logic [2:0]    active_colour_q;
  logic [1:0]    pend_tile_q;
  logic [2:0]    pend_colour_q;
  logic          pend_valid_q;
  logic          pend_start_q;
  logic [CW-1:0] cnt_x_q;
  logic [CW-1:0] cnt_y_q;

  logic       start;
  logic [1:0] k;
  logic [2:0] k_colour;
  logic       unused_tn2;

  assign start      = bus.writeEnable & bus.counterEnable;
  assign k          = bus.tile_num[1:0];
  assign k_colour   = normal_colour(k);
  assign unused_tn2 = bus.tile_num[2];

  // DONE merge: pending contents first, then this cycle's loads on top.
  logic [1:0] done_tile_d;
  logic [2:0] done_colour_d;

  always_comb begin
    done_tile_d   = pend_valid_q ? pend_tile_q : active_tile_q;
    done_colour_d = pend_valid_q ? pend_colour_q : active_colour_q;
    if (bus.ld_tile) begin
      done_tile_d   = k;
      done_colour_d = k_colour;
    end
    if (bus.ld_flash) done_colour_d = FLASH_COLOUR;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q         <= IDLE;
      active_tile_q   <= '0;
      active_colour_q <= '0;
      pend_tile_q     <= '0;
      pend_colour_q   <= '0;
      pend_valid_q    <= 1'b0;
      pend_start_q    <= 1'b0;
      cnt_x_q         <= '0;
      cnt_y_q         <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.ld_tile) active_tile_q <= k;
          if (bus.ld_flash)
            active_colour_q <= FLASH_COLOUR;
          else if (bus.ld_tile)
            active_colour_q <= k_colour;
          if (start) begin
            cnt_x_q <= '0;
            cnt_y_q <= '0;
            state_q <= DRAW;
          end
        end
        DRAW: begin
          if (cnt_x_q == LAST) begin
            cnt_x_q <= '0;
            if (cnt_y_q == LAST)
              state_q <= DONE;
            else
              cnt_y_q <= cnt_y_q + ONE;
          end else begin
            cnt_x_q <= cnt_x_q + ONE;
          end
          if (bus.ld_tile) begin
            pend_tile_q  <= k;
            pend_valid_q <= 1'b1;
          end
          if (bus.ld_flash) begin
            pend_colour_q <= FLASH_COLOUR;
            pend_valid_q  <= 1'b1;
            // Flash alone keeps the tile currently being drawn.
            if (!pend_valid_q && !bus.ld_tile)
              pend_tile_q <= active_tile_q;
          end else if (bus.ld_tile) begin
            pend_colour_q <= k_colour;
          end
          if (start) pend_start_q <= 1'b1;
        end
        DONE: begin
          active_tile_q   <= done_tile_d;
          active_colour_q <= done_colour_d;
          pend_valid_q    <= 1'b0;
          pend_start_q    <= 1'b0;
          cnt_x_q         <= '0;
          cnt_y_q         <= '0;
          if (pend_start_q || start)
            state_q <= DRAW;
          else
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.x      = 8'd0;
    bus.y      = 7'd0;
    bus.colour = 3'd0;
    if (state_q == DRAW) begin
      bus.x = (active_tile_q[0] ? BX1 : BX0)
            + 8'(cnt_x_q);
      bus.y = (active_tile_q[1] ? BY1 : BY0)
            + 7'(cnt_y_q);
      bus.colour = active_colour_q;
    end
  end

  assign bus.plot      = (state_q == DRAW);
  assign bus.busy      = (state_q != IDLE);
  assign bus.draw_done = (state_q == DONE);

endmodule
